dense_mac: RTL



---
 rtl/dense_mac.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dense_mac.sv
// -----------------------------------------------------------------------------
// dense_mac
//
// Fixed-point dense-layer engine: y = W*x + b for N_OUT outputs over N_IN
// inputs. One input element is consumed per cycle. All N_OUT outputs are
// handled in parallel, and the block uses a start/busy/done handshake.
//
// Pipeline per element j:
//   MAC cycle   : prod[i] <= sat((x[j]*w(j,i)) >>> FRAC)
//   next cycle  : acc[i]  <= acc[i] + prod[i]
// The DRAIN state absorbs the final product. WRITE saturates the accumulators
// into y and pulses done.
//
// Optional feature macro: DENSE_MAC_RELU_EN
//   defined   -> negative accumulators are written as 0 (ReLU)
//   undefined -> accumulators are saturated and written signed
//
// Parameters:
//   BITSIZE  word width (two's complement)
//   FRAC     fractional bits; 1.0 == 1<<FRAC
//   N_IN     input vector length (>=1)
//   N_OUT    output vector length (>=1)
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-low reset
//   start  in   request, sampled only while idle
//   x      in   element j at x[BITSIZE*j +: BITSIZE]
//   w      in   weight(j,i) at w[BITSIZE*(N_OUT*j+i) +: BITSIZE]
//   b      in   bias i at b[BITSIZE*i +: BITSIZE]
//   y      out  result i at y[BITSIZE*i +: BITSIZE], registered
//   busy   out  high while an accepted operation is in flight
//   done   out  one-cycle pulse when y is updated
//
// x, w and b must stay stable from start acceptance until done.
// -----------------------------------------------------------------------------
module dense_mac #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8,
  parameter int N_IN    = 10,
  parameter int N_OUT   = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BITSIZE*N_IN-1:0]    x,
  input  logic [BITSIZE*N_IN*N_OUT-1:0] w,
  input  logic [BITSIZE*N_OUT-1:0]   b,
  output logic [BITSIZE*N_OUT-1:0]   y,
  output logic                       busy,
  output logic                       done
);

  // Headroom for N_IN products plus the bias, so the accumulator never wraps.
  localparam int ACC_W = BITSIZE + $clog2(N_IN + 1);
  localparam int PW    = 2 * BITSIZE;
  localparam int JW    = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic signed [PW-1:0] P_MAX =
    {{(PW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN =
    {{(PW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] A_MAX =
    {{(ACC_W-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN =
    {{(ACC_W-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // Clamp a shifted full-width product to BITSIZE.
  function automatic logic [BITSIZE-1:0] sat_prod(input logic signed [PW-1:0] v);
    logic [BITSIZE-1:0] r;
    if (v > P_MAX) begin
      r = {1'b0, {(BITSIZE-1){1'b1}}};
    end else if (v < P_MIN) begin
      r = {1'b1, {(BITSIZE-1){1'b0}}};
    end else begin
      r = v[BITSIZE-1:0];
    end
    return r;
  endfunction

  // Clamp an accumulator to BITSIZE.
  function automatic logic [BITSIZE-1:0] sat_acc(input logic signed [ACC_W-1:0] v);
    logic [BITSIZE-1:0] r;
    if (v > A_MAX) begin
      r = {1'b0, {(BITSIZE-1){1'b1}}};
    end else if (v < A_MIN) begin
      r = {1'b1, {(BITSIZE-1){1'b0}}};
    end else begin
      r = v[BITSIZE-1:0];
    end
    return r;
  endfunction

  // Q-format multiply: full-width signed product, floor shift, then saturate.
  function automatic logic [BITSIZE-1:0] mul_q(input logic signed [BITSIZE-1:0] a,
                                               input logic signed [BITSIZE-1:0] c);
    logic signed [PW-1:0] full;
    full = a * c;
    return sat_prod(full >>> FRAC);
  endfunction

  // Output stage, with optional ReLU.
  function automatic logic [BITSIZE-1:0] out_fn(input logic signed [ACC_W-1:0] v);
    logic [BITSIZE-1:0] r;
`ifdef DENSE_MAC_RELU_EN
    if (v[ACC_W-1]) begin
      r = '0;
    end else begin
      r = sat_acc(v);
    end
`else
    r = sat_acc(v);
`endif
    return r;
  endfunction

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [JW-1:0]              r_j;
  logic                       w_j_last;
  logic                       r_prod_valid;
  logic [BITSIZE-1:0]         r_prod [N_OUT];
  logic [BITSIZE-1:0]         w_prod [N_OUT];
  logic signed [ACC_W-1:0]    r_acc  [N_OUT];
  logic [BITSIZE*N_OUT-1:0]   r_y;
  logic                       r_busy;
  logic                       r_done;

  assign w_j_last = (r_j == JW'(N_IN - 1));
  assign y        = r_y;
  assign busy     = r_busy;
  assign done     = r_done;

  // Products of the current element x[j] against every output's weight.
  always_comb begin
    for (int i = 0; i < N_OUT; i++) begin
      w_prod[i] = mul_q(x[BITSIZE*int'(r_j) +: BITSIZE],
                        w[BITSIZE*(N_OUT*int'(r_j) + i) +: BITSIZE]);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_MAC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MAC: begin
        if (w_j_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_MAC;
        end
      end
      S_DRAIN: w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath: element counter, product stage, accumulators, outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_j          <= '0;
      r_prod_valid <= 1'b0;
      r_y          <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      for (int i = 0; i < N_OUT; i++) begin
        r_prod[i] <= '0;
        r_acc[i]  <= '0;
      end
    end else begin
      // Product stage runs only in MAC; prod_valid lags it by one cycle.
      if (r_state == S_MAC) begin
        r_prod       <= w_prod;
        r_prod_valid <= 1'b1;
        r_j          <= w_j_last ? '0 : r_j + JW'(1);
      end else begin
        r_prod_valid <= 1'b0;
        if (r_state == S_IDLE) begin
          r_j <= '0;
        end
      end

      // Accumulator: bias preload on accept, otherwise add the pending product.
      for (int i = 0; i < N_OUT; i++) begin
        if ((r_state == S_IDLE) && start) begin
          r_acc[i] <= {{(ACC_W-BITSIZE){b[BITSIZE*i + BITSIZE-1]}}, b[BITSIZE*i +: BITSIZE]};
        end else if (r_prod_valid) begin
          r_acc[i] <= r_acc[i] + {{(ACC_W-BITSIZE){r_prod[i][BITSIZE-1]}}, r_prod[i]};
        end
      end

      if (r_state == S_WRITE) begin
        for (int i = 0; i < N_OUT; i++) begin
          r_y[BITSIZE*i +: BITSIZE] <= out_fn(r_acc[i]);
        end
      end

      r_done <= (r_state == S_WRITE);
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

endmodule
